nf10_axil_master: RTL and testbench

NF10_AXIL_MASTER -- requirements
Module: nf10_axil_master

---
 rtl/nf10_axil_master.sv | 142 ++++++++++++++
 tb/tb_nf10_axil_master.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/nf10_axil_master.sv
// Single-outstanding AXI4-Lite master: turns a cmd/rsp handshake pair into one AXI-Lite
// read or write. Optional response watchdog enabled by defining AXIL_MASTER_TIMEOUT_EN.
module nf10_axil_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_TIMEOUT_CYCLES   = 1024
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_rnw,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

    state_t                            state, state_nxt;
    logic [C_M_AXI_ADDR_WIDTH-1:0]     addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_q, rdata_q;
    logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb_q;
    logic [1:0]                        resp_q;
    logic                              aw_done, w_done;
    logic                              cmd_hs, aw_hs, w_hs, ar_hs, b_hs, r_hs, tmo;

    assign cmd_hs = cmd_valid && cmd_ready;
    assign aw_hs  = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs   = M_AXI_WVALID && M_AXI_WREADY;
    assign ar_hs  = M_AXI_ARVALID && M_AXI_ARREADY;
    assign b_hs   = M_AXI_BVALID && M_AXI_BREADY;
    assign r_hs   = M_AXI_RVALID && M_AXI_RREADY;

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(C_TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;
    logic             busy;

    assign busy = state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
    assign tmo  = busy && (tmo_cnt == CNT_W'(C_TIMEOUT_CYCLES - 1));

    // Restarts on every state change so each phase gets the full budget.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN)                   tmo_cnt <= '0;
        else if (!busy || state_nxt != state) tmo_cnt <= '0;
        else                                  tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) state <= IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_hs) state_nxt = cmd_rnw ? RD_REQ : WR_REQ;
            WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
                     else if (tmo)                              state_nxt = DONE;
            WR_RESP: if (b_hs || tmo)  state_nxt = DONE;
            RD_REQ:  if (ar_hs)        state_nxt = RD_RESP;
                     else if (tmo)     state_nxt = DONE;
            RD_RESP: if (r_hs || tmo)  state_nxt = DONE;
            DONE:    if (rsp_ready)    state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Readies are gated by reset so nothing is consumed while the block is held.
    always_comb begin
        cmd_ready     = M_AXI_ARESETN && (state == IDLE);
        M_AXI_AWVALID = (state == WR_REQ) && !aw_done;
        M_AXI_WVALID  = (state == WR_REQ) && !w_done;
        M_AXI_ARVALID = (state == RD_REQ);
        M_AXI_BREADY  = M_AXI_ARESETN && (state == IDLE || state == WR_RESP);
        M_AXI_RREADY  = M_AXI_ARESETN && (state == IDLE || state == RD_RESP);
        rsp_valid     = (state == DONE);
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rdata_q <= '0;
            resp_q  <= 2'b00;
        end else begin
            if (cmd_hs) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
            end
            aw_done <= (state == WR_REQ) && (aw_done || aw_hs);
            w_done  <= (state == WR_REQ) && (w_done || w_hs);
            if (state == WR_RESP && b_hs) begin
                resp_q  <= M_AXI_BRESP;
                rdata_q <= '0;
            end else if (state == RD_RESP && r_hs) begin
                resp_q  <= M_AXI_RRESP;
                rdata_q <= M_AXI_RDATA;
            end else if (state != DONE && state_nxt == DONE) begin
                resp_q  <= 2'b11;
                rdata_q <= '0;
            end
        end
    end

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;
    assign rsp_rdata    = rdata_q;
    assign rsp_resp     = resp_q;

endmodule

// File: tb/tb_nf10_axil_master.sv
// Randomized bench for nf10_axil_master: a per-cycle slave driver with delay knobs and a
// transaction-level expectation (response, data, latency) derived from the delays.
module tb_nf10_axil_master;
    localparam int TMO = 16;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] awaddr, wdata, araddr, rdata_in, cmd_addr, cmd_wdata, rsp_rdata;
    logic [3:0]  wstrb, cmd_wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp, rsp_resp;
    logic        cmd_valid, cmd_ready, cmd_rnw, rsp_valid, rsp_ready;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    nf10_axil_master #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .C_TIMEOUT_CYCLES(TMO)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata_in), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts at a negedge with the DUT idle; ends at the negedge after rsp is consumed.
    task automatic run_txn(input bit rnw, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly, input int ar_dly, input int r_dly, input int rsp_dly,
                           input logic [1:0] bresp_v, input logic [1:0] rresp_v,
                           input logic [31:0] rdata_v, input bit exp_tmo);
        logic [1:0]  exp_resp, rr0 = 2'b00;
        logic [31:0] exp_rd, rd0 = '0;
        int exp_lat, k, rsp_at = -1, viol = 0;
        int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
        int aw_n = 0, w_n = 0, ar_n = 0, b_n = 0, r_n = 0;
        bit aw_d = 0, w_d = 0, ar_d = 0, b_d = 0, r_d = 0, done = 0;

        exp_resp = exp_tmo ? 2'b11 : (rnw ? rresp_v : bresp_v);
        exp_rd   = (exp_tmo || !rnw) ? 32'h0 : rdata_v;
        exp_lat  = exp_tmo ? TMO + 1
                 : rnw ? 3 + ar_dly + r_dly
                 : 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;

        cmd_valid = 1; cmd_rnw = rnw; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = strb;
        chk("cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);

        for (k = 1; k <= 400 && !done; k++) begin
            awready = 0; wready = 0; arready = 0; rsp_ready = 0;
            if (b_d) bvalid = 0;
            if (r_d) rvalid = 0;
            if (rsp_valid) begin
                if (rsp_at < 0) begin
                    rsp_at = k; rd0 = rsp_rdata; rr0 = rsp_resp;
                end else if (rsp_rdata !== rd0 || rsp_resp !== rr0) viol++;
                if (k - rsp_at >= rsp_dly) rsp_ready = 1;
            end
            if (cmd_ready) viol++;
            if (rnw ? (awvalid || wvalid) : arvalid) viol++;
            if (awvalid) begin
                if (aw_d || awaddr !== addr) viol++;
                if (aw_cnt >= aw_dly) begin awready = 1; aw_n++; end
                aw_cnt++;
            end
            if (wvalid) begin
                if (w_d || wdata !== wd || wstrb !== strb) viol++;
                if (w_cnt >= w_dly) begin wready = 1; w_n++; end
                w_cnt++;
            end
            if (arvalid) begin
                if (ar_d || araddr !== addr) viol++;
                if (ar_cnt >= ar_dly) begin arready = 1; ar_n++; end
                ar_cnt++;
            end
            if (aw_d && w_d && !b_d) begin
                if (b_cnt >= b_dly) begin bvalid = 1; bresp = bresp_v; end
                else b_cnt++;
                if (bvalid && bready) begin b_n++; b_d = 1; end
            end
            if (ar_d && !r_d) begin
                if (r_cnt >= r_dly) begin rvalid = 1; rresp = rresp_v; rdata_in = rdata_v; end
                else r_cnt++;
                if (rvalid && rready) begin r_n++; r_d = 1; end
            end
            if (rsp_ready) done = 1;
            if (awready) aw_d = 1;
            if (wready)  w_d = 1;
            if (arready) ar_d = 1;
            @(negedge clk);
        end
        bvalid = 0; rvalid = 0; rsp_ready = 0;

        chk("bound", done, 1);
        chk("rsp_resp", rr0, exp_resp);
        chk("rsp_rdata", rd0, exp_rd);
        chk("latency", rsp_at, exp_lat);
        chk("protocol", viol, 0);
        chk("back_idle", {cmd_ready, rsp_valid}, 2'b10);
        if (!exp_tmo) begin
            chk("req_hs", rnw ? ar_n : aw_n + w_n, rnw ? 1 : 2);
            chk("resp_hs", rnw ? r_n : b_n, 1);
        end
        if (exp_tmo && rnw) chk("arvalid_cycles", ar_cnt, TMO);
    endtask

    initial begin
        int quiet;
        {awready, wready, arready, bvalid, rvalid, rsp_ready, cmd_valid, cmd_rnw} = '0;
        {bresp, rresp, rdata_in, cmd_addr, cmd_wdata, cmd_wstrb} = '0;

        repeat (2) @(negedge clk);
        chk("rst_valids", {awvalid, wvalid, arvalid, rsp_valid, cmd_ready}, 0);
        chk("rst_addr_data", {awaddr, araddr, wdata, wstrb}, 0);
        chk("rst_rsp", {rsp_rdata, rsp_resp}, 0);
        rst_n = 1;
        @(negedge clk);
        chk("ready_after_rst", cmd_ready, 1);

        // Directed: always-ready write, WREADY ahead of AWREADY, stalled read consumer.
        run_txn(0, 32'h6a000004, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        run_txn(0, 32'h6a000008, 32'hCAFEF00D, 4'h5, 2, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0);
        run_txn(1, 32'h6a000000, 0, 4'h0, 0, 0, 0, 0, 0, 5, 2'b00, 2'b10, 32'h12345678, 0);

`ifdef AXIL_MASTER_TIMEOUT_EN
        run_txn(1, 32'h6a000000, 0, 4'h0, 0, 0, 0, 1000, 0, 0, 2'b00, 2'b00, 0, 1);
`else
        run_txn(1, 32'h6a000000, 0, 4'h0, 0, 0, 0, 40, 0, 0, 2'b00, 2'b01, 32'h0BADF00D, 0);
`endif
        // Late R and B pulses while idle must be swallowed without a response.
        chk("rready_idle", {rready, bready}, 2'b11);
        rvalid = 1; rdata_in = 32'hFFFF0000; rresp = 2'b01; bvalid = 1; bresp = 2'b10;
        @(negedge clk);
        rvalid = 0; bvalid = 0;
        quiet = 0;
        repeat (4) begin
            if (rsp_valid || !cmd_ready) quiet++;
            @(negedge clk);
        end
        chk("stray_absorbed", quiet, 0);

        for (int i = 0; i < 40; i++)
            run_txn(1'($urandom), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom,
                    4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), 2'($urandom), 2'($urandom), $urandom, 0);

        // Reset while waiting for B: nonzero rsp registers beforehand prove the clear.
        run_txn(1, 32'h6a000010, 0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 32'hA5A5A5A5, 0);
        cmd_valid = 1; cmd_rnw = 0; cmd_addr = 32'h6a000020; cmd_wdata = 32'h11223344;
        cmd_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid = 0; awready = 1; wready = 1;
        @(negedge clk);
        awready = 0; wready = 0;
        chk("wr_resp_state", {awvalid, wvalid, bready}, 3'b001);
        #2 rst_n = 0;
        #1;
        chk("arst_valids", {awvalid, wvalid, arvalid, rsp_valid, cmd_ready}, 0);
        chk("arst_addr_data", {awaddr, araddr, wdata, wstrb}, 0);
        chk("arst_rsp", {rsp_rdata, rsp_resp}, 0);
        bvalid = 1; bresp = 2'b00;
        @(negedge clk);
        @(negedge clk);
        bvalid = 0; rst_n = 1;
        @(negedge clk);
        chk("post_rst", {cmd_ready, rsp_valid}, 2'b10);
        run_txn(0, 32'h6a000024, 32'h55AA55AA, 4'h3, 1, 0, 1, 0, 0, 1, 2'b01, 2'b00, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
